stage3_pool_ctrl: RTL and testbench

Frame-level sequencer for the stage-3 2x2/stride-2 max-pooling datapath. It tracks the row/column position of every ReLU pixel entering the line buffers and marks the cycles on which a complete 2x2 window is available. It delays that mark to line up with the registered pooling result, and tags each pooled output with its linear index. It also brackets each feature map with start/busy/done status for the surrounding stage controller.

---
 rtl/stage3_pool_ctrl_pkg.sv | 17 +
 rtl/stage3_valid_delay.sv | 34 +++
 rtl/stage3_pool_ctrl.sv | 149 ++++++++++++++
 tb/tb_stage3_pool_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage3_pool_ctrl_pkg.sv
// Shared stage-3 pooling definitions: window size, default pooling latency and
// the frame sequencer state encodings.
package stage3_pool_ctrl_pkg;

  // 2x2 window, stride 2
  localparam int unsigned POOL_K = 2;

  // Cycles from window-valid to pooled-result-valid in the stage-3 datapath
  localparam int unsigned S3_POOL_LAT = 2;

  // Frame sequencer states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/stage3_valid_delay.sv
// Fixed-depth shift register carrying the window-valid strobe alongside the
// pooling datapath. It shifts every cycle regardless of the frame state.
module stage3_valid_delay #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_valid,
  output logic o_valid
);

  logic [Depth-1:0] sr_q, sr_d;

  // Next state: shift the strobe one stage deeper
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = i_valid;
    for (int unsigned i = 1; i < Depth; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Shift register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_valid = sr_q[Depth-1];

endmodule

// File: rtl/stage3_pool_ctrl.sv
// Frame-level sequencer for the stage-3 2x2/stride-2 max-pooling datapath.
// Tracks pixel position, flags complete windows, aligns the flag with the
// pooled result, tags outputs with a linear index and brackets the frame.
module stage3_pool_ctrl
  import stage3_pool_ctrl_pkg::*;
#(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned IN_H     = 8,
  parameter int unsigned POOL_LAT = S3_POOL_LAT,
  parameter int unsigned IDX_BW   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_busy,
  output logic              o_lb_wr_en,
  output logic              o_win_valid,
  output logic              o_pool_valid,
  output logic [IDX_BW-1:0] o_out_idx,
  output logic              o_frame_done,
  output logic              o_err
);

  localparam int unsigned CW = $clog2(IN_W);
  localparam int unsigned RW = $clog2(IN_H);
  localparam int unsigned DW = $clog2(POOL_LAT + 2);

  // Odd trailing row/column never completes a window (floor)
  localparam logic [CW-1:0] ColLast   = CW'(IN_W - 1);
  localparam logic [RW-1:0] RowLast   = RW'(IN_H - 1);
  localparam logic [CW-1:0] ColWinMax = CW'(POOL_K * (IN_W / POOL_K) - 1);
  localparam logic [RW-1:0] RowWinMax = RW'(POOL_K * (IN_H / POOL_K) - 1);
  localparam logic [DW-1:0] DrainLast = DW'(POOL_LAT);

  logic [1:0]        state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [IDX_BW-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              win_valid_q;
  logic              pool_valid;

  logic accept, start_ok, last_pix, win;

  assign accept   = i_in_valid && (state_q == StRun);
  assign start_ok = i_start && (state_q == StIdle);
  assign last_pix = accept && (row_q == RowLast) && (col_q == ColLast);
  assign win      = accept && row_q[0] && col_q[0] &&
                    (row_q <= RowWinMax) && (col_q <= ColWinMax);

  // Frame FSM and pixel position counters
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == ColLast) begin
            col_d = '0;
            row_d = last_pix ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_pix) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        // Hold off DONE until the last window has left the valid pipeline
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sticky protocol error and output index
  always_comb begin
    err_d = err_q;
    if (start_ok) begin
      err_d = 1'b0;
    end
    if ((i_start && !start_ok) || (i_in_valid && !accept)) begin
      err_d = 1'b1;
    end
    idx_d = idx_q;
    if (start_ok) begin
      idx_d = '0;
    end else if (pool_valid) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      drain_q     <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drain_q     <= drain_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      win_valid_q <= win;
    end
  end

  stage3_valid_delay #(
    .Depth(POOL_LAT)
  ) u_valid_delay (
    .clk    (clk),
    .reset_n(reset_n),
    .i_valid(win_valid_q),
    .o_valid(pool_valid)
  );

  assign o_busy       = (state_q == StRun) || (state_q == StDrain);
  assign o_lb_wr_en   = accept;
  assign o_win_valid  = win_valid_q;
  assign o_pool_valid = pool_valid;
  assign o_out_idx    = idx_q;
  assign o_frame_done = (state_q == StDone);
  assign o_err        = err_q;

endmodule

// File: tb/tb_stage3_pool_ctrl.sv
// Bench for stage3_pool_ctrl: an 8x8 and a 5x5 instance, each with a
// scoreboard of expected window/pool events keyed by cycle number.
module tb_stage3_pool_ctrl;

  localparam int W0  = 8;
  localparam int H0  = 8;
  localparam int W1  = 5;
  localparam int H1  = 5;
  localparam int LAT = 2;
  localparam int BIG = 1 << 30;

  typedef struct packed {
    int cyc;
    int idx;
  } pexp_t;

  logic       clk;
  logic       reset_n;
  logic       start_i [2];
  logic       valid_i [2];
  logic       busy_o  [2];
  logic       wr_o    [2];
  logic       win_o   [2];
  logic       pv_o    [2];
  logic [7:0] idx_o   [2];
  logic       done_o  [2];
  logic       err_o   [2];

  int    cyc = 0;
  int    n_chk = 0;
  int    n_bad = 0;

  // Reference model state per instance
  pexp_t pool_q [2][$];
  int    win_q  [2][$];
  bit    m_run      [2];
  int    m_row      [2];
  int    m_col      [2];
  int    m_done     [2];
  int    m_bstart   [2];
  int    m_bend     [2];
  bit    m_err_pend [2];
  bit    m_err      [2];

  stage3_pool_ctrl #(
    .IN_W(W0), .IN_H(H0), .POOL_LAT(LAT), .IDX_BW(8)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .i_start(start_i[0]), .i_in_valid(valid_i[0]),
    .o_busy(busy_o[0]), .o_lb_wr_en(wr_o[0]), .o_win_valid(win_o[0]),
    .o_pool_valid(pv_o[0]), .o_out_idx(idx_o[0]), .o_frame_done(done_o[0]),
    .o_err(err_o[0])
  );

  stage3_pool_ctrl #(
    .IN_W(W1), .IN_H(H1), .POOL_LAT(LAT), .IDX_BW(8)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .i_start(start_i[1]), .i_in_valid(valid_i[1]),
    .o_busy(busy_o[1]), .o_lb_wr_en(wr_o[1]), .o_win_valid(win_o[1]),
    .o_pool_valid(pv_o[1]), .o_out_idx(idx_o[1]), .o_frame_done(done_o[1]),
    .o_err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    m_err[0] <= m_err_pend[0];
    m_err[1] <= m_err_pend[1];
  end

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // Per-cycle output comparison against the scoreboard
  always @(negedge clk) begin
    bit ew, ep;
    for (int d = 0; d < 2; d++) begin
      ew = (win_q[d].size() > 0) && (win_q[d][0] == cyc);
      check("win_valid", int'(win_o[d]), int'(ew));
      if (ew) void'(win_q[d].pop_front());
      ep = (pool_q[d].size() > 0) && (pool_q[d][0].cyc == cyc);
      check("pool_valid", int'(pv_o[d]), int'(ep));
      if (ep) begin
        check("out_idx", int'(idx_o[d]), pool_q[d][0].idx);
        void'(pool_q[d].pop_front());
      end
      check("frame_done", int'(done_o[d]), int'(cyc == m_done[d]));
      check("busy", int'(busy_o[d]), int'(cyc >= m_bstart[d] && cyc < m_bend[d]));
      check("err", int'(err_o[d]), int'(m_err[d]));
    end
  end

  // Drive one cycle of stimulus on instance d and update its model
  task automatic step(input int d, input bit s, input bit v);
    int  e, w, h, r, c;
    bit  acc, idle;
    pexp_t pe;
    @(posedge clk);
    #1;
    start_i[0] = 1'b0; start_i[1] = 1'b0;
    valid_i[0] = 1'b0; valid_i[1] = 1'b0;
    start_i[d] = s;
    valid_i[d] = v;
    e = cyc + 1;
    w = (d == 0) ? W0 : W1;
    h = (d == 0) ? H0 : H1;
    acc  = v && m_run[d];
    idle = !m_run[d] && (e >= m_done[d] + 2);
    if (s && idle) begin
      m_run[d]      = 1'b1;
      m_row[d]      = 0;
      m_col[d]      = 0;
      m_bstart[d]   = e;
      m_bend[d]     = BIG;
      m_done[d]     = BIG;
      m_err_pend[d] = 1'b0;
    end
    if ((s && !idle) || (v && !acc)) m_err_pend[d] = 1'b1;
    #1;
    check("lb_wr_en", int'(wr_o[d]), int'(acc));
    if (acc) begin
      r = m_row[d];
      c = m_col[d];
      if ((r % 2 == 1) && (c % 2 == 1) && (r <= 2 * (h / 2) - 1) && (c <= 2 * (w / 2) - 1)) begin
        win_q[d].push_back(e);
        pe.cyc = e + LAT;
        pe.idx = (r / 2) * (w / 2) + c / 2;
        pool_q[d].push_back(pe);
      end
      if (c == w - 1) begin
        m_col[d] = 0;
        m_row[d] = r + 1;
      end else begin
        m_col[d] = c + 1;
      end
      if (r == h - 1 && c == w - 1) begin
        m_run[d]  = 1'b0;
        m_done[d] = e + 1 + LAT;
        m_bend[d] = m_done[d];
      end
    end
  endtask

  // Idle until the cycle showing o_frame_done
  task automatic wait_done(input int d);
    for (int i = 0; i < 50 && cyc < m_done[d]; i++) step(d, 1'b0, 1'b0);
  endtask

  task automatic reset_checks();
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", int'(busy_o[d]), 0);
      check("rst_wr_en", int'(wr_o[d]), 0);
      check("rst_win", int'(win_o[d]), 0);
      check("rst_pool", int'(pv_o[d]), 0);
      check("rst_idx", int'(idx_o[d]), 0);
      check("rst_done", int'(done_o[d]), 0);
      check("rst_err", int'(err_o[d]), 0);
    end
  endtask

  // Mid-run reset: everything due from the reset edge onward is discarded
  task automatic do_reset(input int ncyc);
    int e;
    @(posedge clk);
    #1;
    e = cyc + 1;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0;
      valid_i[d] = 1'b0;
      while (pool_q[d].size() > 0 && pool_q[d][$].cyc >= e) void'(pool_q[d].pop_back());
      while (win_q[d].size() > 0 && win_q[d][$] >= e) void'(win_q[d].pop_back());
      m_run[d] = 1'b0;
      if (m_done[d] >= e) m_done[d] = -10;
      if (m_bend[d] > e) m_bend[d] = e;
      m_err_pend[d] = 1'b0;
    end
    repeat (ncyc - 1) @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_checks();
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_i[d]  = 1'b0;
      valid_i[d]  = 1'b0;
      m_run[d]    = 1'b0;
      m_done[d]   = -10;
      m_bstart[d] = BIG;
      m_bend[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_checks();

    // Pixel in IDLE: not written, raises err
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);

    // Full 8x8 frame, back-to-back pixels; start clears err
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) step(0, 1'b0, 1'b1);
    wait_done(0);

    // Next frame starts the cycle after frame_done, gapped input,
    // stray start in RUN and in DRAIN
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(0, 1'b0, 1'b1);
      step(0, (i == 30), 1'b0);
    end
    step(0, 1'b1, 1'b0);
    wait_done(0);
    step(0, 1'b0, 1'b0);

    // Reset after pixel 20, and again right after window pixel (3,3)
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 21; i++) step(0, 1'b0, 1'b1);
    do_reset(2);
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 28; i++) step(0, 1'b0, 1'b1);
    do_reset(2);

    // Fresh frame restarts at idx 0
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) step(0, 1'b0, 1'b1);
    wait_done(0);
    step(0, 1'b0, 1'b0);

    // Odd 5x5 frame: last row and column discarded
    step(1, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step(1, 1'b0, 1'b1);
    wait_done(1);
    step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);

    check("pending0", pool_q[0].size() + win_q[0].size(), 0);
    check("pending1", pool_q[1].size() + win_q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
